present_stream_loader: RTL
==========================

# present_stream_loader

Byte-stream front end for the 80-bit-key, 64-bit-block combinational PRESENT encryption core (`encrypt_v1`).
- Upstream side: assembles plaintext bytes into 64-bit blocks and holds the 80-bit key.
- Core side: drives `k`/`m` into the core and captures `c` after a fixed settle window.
- Downstream side: serialises the ciphertext back out as bytes under a valid/ready handshake.
- Optional CBC chaining is compiled in by macro.

## Interface
Parameters:
- `ENC_WAIT`, default 2: cycles `core_m`/`core_k` are held stable before `core_c` is captured. Range 1..15.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `key_load`  in  1  strobe: latch `key_in` (and `iv_in`).
- `key_in`  in  80  cipher key.
- `iv_in`  in  64  CBC initial vector; ignored without CBC.
- `din`  in  8  plaintext byte.
- `din_valid`  in  1  `din` valid.
- `din_ready`  out  1  block accepts a byte.
- `dout`  out  8  ciphertext byte.
- `dout_valid`  out  1  `dout` valid.
- `dout_ready`  in  1  consumer accepts `dout`.
- `busy`  out  1  high in ENC or OUT.
- `core_k`  out  80  key to core.
- `core_m`  out  64  message to core.
- `core_c`  in  64  ciphertext from core.

## Operation
States: LOAD, ENC, OUT.

Reset values:
- State LOAD, byte count 0, wait count 0.
- Key, block, chain and ciphertext registers 0.
- `dout`=0, `dout_valid`=0, `busy`=0, `din_ready`=1.
- `core_k`=0, `core_m`=0.

LOAD state:
- `din_ready`=1.
- On each `din_valid`, the byte shifts into the block register: first byte lands in bits [63:56], eighth in [7:0].
- 3-bit byte count increments and wraps 7->0.
- Accepting the eighth byte moves to ENC and loads `core_m` (see Configuration).

`key_load`:
- Honoured only in LOAD with byte count 0; latches `key_in` into `core_k` and `iv_in` into the chain register.
- Ignored in all other states and counts; a partial block is never re-keyed.
- If `key_load` and `din_valid` occur in the same cycle, both are honoured, and the block uses the new key.

ENC state:
- `din_ready`=0 and `busy`=1.
- `core_m` and `core_k` are held.
- The wait counter counts `ENC_WAIT` cycles. In the last ENC cycle, `core_c` is registered into the ciphertext register, and the state moves to OUT.

OUT state:
- `dout_valid`=1 and `dout`=ciphertext[63:56].
- On each `dout_valid && dout_ready`, the register shifts left 8 bits.
- After the eighth handshake: return to LOAD, `dout_valid`=0, byte count 0.
- `dout` is held stable while `dout_valid && !dout_ready`.
- `din_valid` in ENC or OUT is ignored, because `din_ready`=0.

Asynchronous reset mid-operation aborts the block: all registers return to reset values, the key is lost, and no partial output is emitted.

## Timing
- Byte accept: one per cycle while in LOAD.
- Eighth byte accepted on edge t: `core_m` valid from t; ENC spans edges t+1..t+`ENC_WAIT`; capture on edge t+`ENC_WAIT`.
- `dout_valid` rises after edge t+`ENC_WAIT`, i.e. first ciphertext byte available `ENC_WAIT`+1 cycles after the last plaintext byte.
- With `dout_ready` held high, the 8 output bytes take 8 cycles, and `din_ready` returns the cycle after the last output handshake.
- Minimum period per block: 8 + `ENC_WAIT` + 8 cycles.
- `ENC_WAIT` must cover the core's combinational delay; the block does no timing check.

## Configuration
`PRESENT_CBC_EN`:
- Defined:
  - `core_m` = block XOR chain.
  - On capture, the chain register is loaded with `core_c`.
  - `key_load` reloads the chain from `iv_in`.
- Undefined (ECB):
  - `core_m` = block.
  - There is no chain register, and `iv_in` is unused.

## Test plan
- Reset; key 0, 8 bytes of 00 -> output bytes 55 79 C1 38 7B 22 84 45; `dout_valid` first high `ENC_WAIT`+1 cycles after the eighth byte.
- Key FFFF_FFFF_FFFF_FFFF_FFFF, plaintext 00×8 -> E72C46C0F5945049; same key, plaintext FF×8 -> 3333DCD3213210D2.
- Back-pressure: `dout_ready` low for 5 cycles mid-block -> `dout` and `dout_valid` stable, no bytes lost or duplicated, `din_ready`=0 throughout.
- `key_load` with key FF…FF during ENC, then a second block 00×8 -> second block still encrypted under key 0 (5579C1387B228445); `key_load` at byte count 0 of LOAD takes effect.
- `PRESENT_CBC_EN`, key 0, IV 0: block 1 = 00×8 -> 5579C1387B228445; block 2 = 5579C1387B228445 -> 5579C1387B228445. Without macro, block 2 -> E(key 0, 5579C1387B228445), not equal to block 1's output.
- `rst` asserted asynchronously after 4 bytes -> all outputs at reset values immediately; the next 8 bytes of 00 with key 0 -> 5579C1387B228445.

Source files
------------

// File: rtl/present_stream_loader.sv
`default_nettype none
// ============================================================================
// Module      : present_stream_loader
// Description : Byte-stream front end for a combinational PRESENT-80 core.
//               Optional CBC chaining when PRESENT_CBC_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module present_stream_loader #(
    parameter int ENC_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        key_load,
    input  logic [79:0] key_in,
    input  logic [63:0] iv_in,
    input  logic [7:0]  din,
    input  logic        din_valid,
    output logic        din_ready,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        busy,
    output logic [79:0] core_k,
    output logic [63:0] core_m,
    input  logic [63:0] core_c
);

    localparam logic [1:0] c_st_load = 2'd0;
    localparam logic [1:0] c_st_enc  = 2'd1;
    localparam logic [1:0] c_st_out  = 2'd2;
    localparam logic [3:0] c_wait_last = 4'(ENC_WAIT - 1);

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic [2:0]  r_byte_cnt;
    logic [3:0]  r_wait_cnt;
    logic [63:0] r_block;
    logic [79:0] r_key;
    logic [63:0] r_core_m;
    logic [63:0] r_ct;
    logic [63:0] w_block_next;
    logic [63:0] w_chain;

    assign w_block_next = {r_block[55:0], din};

`ifdef PRESENT_CBC_EN
    logic [63:0] r_chain;
    assign w_chain = r_chain;
`else
    logic w_unused_iv;
    assign w_unused_iv = ^iv_in;
    assign w_chain     = 64'd0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_st_load;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_load: if (din_valid && r_byte_cnt == 3'd7) w_state_next = c_st_enc;
            c_st_enc:  if (r_wait_cnt == c_wait_last) w_state_next = c_st_out;
            c_st_out:  if (dout_ready && r_byte_cnt == 3'd7) w_state_next = c_st_load;
            default:   w_state_next = c_st_load;
        endcase
    end

    always_comb begin
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        busy       = 1'b0;
        case (r_state)
            c_st_load: din_ready = 1'b1;
            c_st_enc:  busy = 1'b1;
            c_st_out: begin
                busy       = 1'b1;
                dout_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign dout   = r_ct[63:56];
    assign core_k = r_key;
    assign core_m = r_core_m;

    // The byte counter doubles as the output handshake counter in OUT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_byte_cnt <= 3'd0;
            r_wait_cnt <= 4'd0;
            r_block    <= 64'd0;
            r_key      <= 80'd0;
            r_core_m   <= 64'd0;
            r_ct       <= 64'd0;
`ifdef PRESENT_CBC_EN
            r_chain    <= 64'd0;
`endif
        end else begin
            case (r_state)
                c_st_load: begin
                    // Re-keying only between blocks, so a partial block keeps one key.
                    if (key_load && r_byte_cnt == 3'd0) begin
                        r_key <= key_in;
`ifdef PRESENT_CBC_EN
                        r_chain <= iv_in;
`endif
                    end
                    if (din_valid) begin
                        r_block    <= w_block_next;
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                        if (r_byte_cnt == 3'd7) begin
                            r_core_m <= w_block_next ^ w_chain;
                        end
                    end
                end
                c_st_enc: begin
                    if (r_wait_cnt == c_wait_last) begin
                        r_wait_cnt <= 4'd0;
                        r_ct       <= core_c;
`ifdef PRESENT_CBC_EN
                        r_chain    <= core_c;
`endif
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 4'd1;
                    end
                end
                c_st_out: begin
                    if (dout_ready) begin
                        r_ct       <= {r_ct[55:0], 8'h00};
                        r_byte_cnt <= r_byte_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
